// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and bus widths for the data-memory responder
package dmem_pkg;
    localparam int WORD_W = 32;
    localparam int STRB_W = 4;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word storage with byte-lane writes and a registered, zeroable read port
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_en,
    input  logic [STRB_W-1:0]              wr_strb,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
    input  logic [WORD_W-1:0]              wdata,
    input  logic                           rd_en,
    input  logic                           rd_zero,
    output logic [WORD_W-1:0]              rdata
);
    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    // storage is deliberately unreset so contents survive a reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < STRB_W; i++)
            if (wr_en && wr_strb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    // read register captures the word on a load, or zero for stores/rejected requests
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdata <= '0;
        else if (rd_en) rdata <= rd_zero ? '0 : mem[idx];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage load/store responder with fixed latency; DMEM_ALIGN_CHECK_EN enables misaligned-request rejection
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);
    localparam int AW     = $clog2(DEPTH_WORDS);
    localparam int CW     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam bit DIRECT = (LATENCY == 1);

    state_t            state, state_next;
    logic [CW-1:0]     cnt;
    logic              wr_q;
    logic [AW+1:0]     addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              accept, do_acc, a_write, a_err;
    logic [AW+1:0]     a_addr;
    logic [WORD_W-1:0] a_wdata;
    logic [STRB_W-1:0] a_wstrb;

    assign accept = req_valid & req_ready;

`ifdef DMEM_ALIGN_CHECK_EN
    assign a_err = |a_addr[1:0];
`else
    assign a_err = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_next;
    end

    // next-state: accept -> countdown -> response held until taken
    always_comb begin
        state_next = (state == IDLE && accept)    ? (DIRECT ? RESP : WAIT) :
                     (state == WAIT && cnt == '0) ? RESP :
                     (state == RESP && resp_ready) ? IDLE : state;
    end

    // access strobe and operand select: a single-cycle latency uses the live request
    always_comb begin
        a_write = DIRECT ? req_write : wr_q;
        a_addr  = DIRECT ? req_addr[AW+1:0] : addr_q;
        a_wdata = DIRECT ? req_wdata : wdata_q;
        a_wstrb = DIRECT ? req_wstrb : wstrb_q;
        do_acc  = DIRECT ? accept : (state == WAIT && cnt == '0);
    end

    // request latches and latency countdown
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (accept) begin
            cnt     <= CW'(LATENCY - 1);
            wr_q    <= req_write;
            addr_q  <= req_addr[AW+1:0];
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end else if (state == WAIT) begin
            cnt <= cnt - 1'b1;
        end
    end

    // registered handshake/status outputs track the upcoming state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            req_ready  <= state_next == IDLE;
            resp_valid <= state_next == RESP;
            busy       <= state_next != IDLE;
            if (do_acc) resp_err <= a_err;
        end
    end

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (do_acc & a_write & ~a_err),
        .wr_strb (a_wstrb),
        .idx     (a_addr[AW+1:2]),
        .wdata   (a_wdata),
        .rd_en   (do_acc),
        .rd_zero (a_write | a_err),
        .rdata   (resp_rdata)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder (DEPTH_WORDS=256, LATENCY=2)
module tb_dmem_responder;
    logic        clk = 0, reset = 1;
    logic        req_valid = 0, req_write = 0, resp_ready = 1;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0]  req_wstrb = 0;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;
    int          vectors = 0, miscompares = 0, cyc = 0;
    logic [31:0] rd;
    logic        er;
    int          lat, a1, a2;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_wstrb(req_wstrb), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        vectors++;
        if (req_ready && resp_valid) begin
            miscompares++;
            $display("FAIL ready_valid_exclusive got both high want not both");
        end
    end

    // called at a negedge; returns at the negedge after the response is taken (or held)
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] r, output logic e, output int l, output int at);
        int n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin
            vectors++; miscompares++;
            $display("FAIL txn_ready_timeout got req_ready=0 want 1");
        end
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        @(posedge clk); #1 at = cyc;
        @(negedge clk); req_valid = 0;
        l = 0;
        while (!resp_valid && l < 20) begin @(negedge clk); l++; end
        r = resp_rdata; e = resp_err;
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        vectors++;
        if ({req_ready, resp_valid, busy, resp_err, resp_rdata} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b err=%b rdata=%h want all 0",
                     req_ready, resp_valid, busy, resp_err, resp_rdata);
        end
        reset = 0; #1;
        vectors++;
        if (req_ready !== 1'b0) begin miscompares++; $display("FAIL ready_before_edge got %b want 0", req_ready); end
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++; $display("FAIL ready_after_reset got rdy=%b busy=%b want 1 0", req_ready, busy);
        end
    endtask

    task automatic test_store_load;
        txn(1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, a1);
        vectors++;
        if (lat !== 2 || rd !== 32'h0 || er !== 1'b0) begin
            miscompares++; $display("FAIL store_resp got lat=%0d rdata=%h err=%b want 2 0 0", lat, rd, er);
        end
        txn(0, 32'h10, 32'h0, 4'h0, rd, er, lat, a1);
        vectors++;
        if (lat !== 2 || rd !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL load_resp got lat=%0d rdata=%h want 2 deadbeef", lat, rd);
        end
    endtask

    task automatic test_byte_lanes;
        txn(1, 32'h20, 32'h11223344, 4'hF, rd, er, lat, a1);
        txn(1, 32'h20, 32'hAABBCCDD, 4'h5, rd, er, lat, a1);
        txn(0, 32'h20, 32'h0, 4'h0, rd, er, lat, a1);
        vectors++;
        if (rd !== 32'h11BB33DD) begin miscompares++; $display("FAIL byte_lanes got %h want 11bb33dd", rd); end
        txn(1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, lat, a1);
        vectors++;
        if (lat !== 2 || rd !== 32'h0 || er !== 1'b0) begin
            miscompares++; $display("FAIL zero_strb_ack got lat=%0d rdata=%h err=%b want 2 0 0", lat, rd, er);
        end
        txn(0, 32'h20, 32'h0, 4'h0, rd, er, lat, a1);
        vectors++;
        if (rd !== 32'h11BB33DD) begin miscompares++; $display("FAIL zero_strb_data got %h want 11bb33dd", rd); end
    endtask

    task automatic test_backpressure;
        resp_ready = 0;
        txn(0, 32'h20, 32'h0, 4'h0, rd, er, lat, a1);
        vectors++;
        if (lat !== 2 || rd !== 32'h11BB33DD) begin
            miscompares++; $display("FAIL bp_resp got lat=%0d rdata=%h want 2 11bb33dd", lat, rd);
        end
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h11BB33DD || req_ready !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold got vld=%b rdata=%h rdy=%b busy=%b want 1 11bb33dd 0 1",
                         resp_valid, resp_rdata, req_ready, busy);
            end
        end
        resp_ready = 1;
        @(negedge clk);
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_release got vld=%b rdy=%b want 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_wrap;
        txn(1, 32'h400, 32'h55, 4'hF, rd, er, lat, a1);
        txn(0, 32'h000, 32'h0, 4'h0, rd, er, lat, a1);
        vectors++;
        if (rd !== 32'h55) begin miscompares++; $display("FAIL wrap got %h want 00000055", rd); end
    endtask

    task automatic test_reset_mid_wait;
        bit seen = 0;
        txn(1, 32'h30, 32'h0, 4'hF, rd, er, lat, a1);
        req_valid = 1; req_write = 1; req_addr = 32'h30; req_wdata = 32'h99; req_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk); req_valid = 0; reset = 1; #1;
        vectors++;
        if (busy !== 1'b0 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset_force got busy=%b rdy=%b vld=%b want 0 0 0", busy, req_ready, resp_valid);
        end
        @(negedge clk); reset = 0;
        repeat (4) begin @(negedge clk); if (resp_valid) seen = 1; end
        vectors++;
        if (seen) begin miscompares++; $display("FAIL mid_reset_noresp got resp_valid=1 want 0"); end
        txn(0, 32'h30, 32'h0, 4'h0, rd, er, lat, a1);
        vectors++;
        if (rd !== 32'h0) begin miscompares++; $display("FAIL mid_reset_drop got %h want 00000000", rd); end
    endtask

    task automatic test_align;
        logic        exp_err;
        logic [31:0] exp_word;
`ifdef DMEM_ALIGN_CHECK_EN
        exp_err = 1; exp_word = 32'h01020304;
`else
        exp_err = 0; exp_word = 32'hFFFFFFFF;
`endif
        txn(1, 32'h10, 32'h01020304, 4'hF, rd, er, lat, a1);
        txn(1, 32'h13, 32'hFFFFFFFF, 4'hF, rd, er, lat, a1);
        vectors++;
        if (lat !== 2 || er !== exp_err || rd !== 32'h0) begin
            miscompares++; $display("FAIL align_resp got lat=%0d err=%b rdata=%h want 2 %b 0", lat, er, rd, exp_err);
        end
        txn(0, 32'h10, 32'h0, 4'h0, rd, er, lat, a1);
        vectors++;
        if (rd !== exp_word || er !== 1'b0) begin
            miscompares++; $display("FAIL align_mem got %h err=%b want %h 0", rd, er, exp_word);
        end
    endtask

    task automatic test_back_to_back;
        txn(0, 32'h20, 32'h0, 4'h0, rd, er, lat, a1);
        vectors++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            miscompares++; $display("FAIL b2b_ready got rdy=%b vld=%b want 1 0", req_ready, resp_valid);
        end
        txn(0, 32'h000, 32'h0, 4'h0, rd, er, lat, a2);
        vectors++;
        if (a2 - a1 !== 4 || rd !== 32'h55) begin
            miscompares++; $display("FAIL b2b_spacing got %0d rdata=%h want 4 00000055", a2 - a1, rd);
        end
    endtask

    initial begin
        test_reset;
        test_store_load;
        test_byte_lanes;
        test_backpressure;
        test_wrap;
        test_reset_mid_wait;
        test_align;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
